// File: rtl/darkuart_bridge.sv
// UART-to-bus bridge: 'W' addr[4] data[4] writes a word and replies 'K';
// 'R' addr[4] reads a word and replies with 4 bytes MSB first; anything else replies '?'.
module darkuart_bridge #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        RXD,
    output logic        TXD,
    output logic        RD,
    output logic        WR,
    output logic [3:0]  BE,
    output logic [31:0] ADDR,
    output logic [31:0] DATAO,
    input  logic [31:0] DATAI,
    output logic        BUSY,
    output logic        ERR
);

    localparam logic [15:0] BitLast  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HalfLast = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {
        StIdle, StGetA, StGetD, StBusW, StBusR, StRCap, StReply
    } state_e;

    // ---------------- receiver ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_valid, rx_frame_err;

    // rxd_prev_q resets low, so no start edge is seen until the line was high once.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_sh_d      = rx_sh_q;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rxd_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    if (rxd_s2_q) begin
                        rx_valid = 1'b1;
                    end else begin
                        rx_frame_err = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------- transmitter ----------------
    logic        tx_busy_q, tx_busy_d;
    logic        txd_q, txd_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [8:0]  tx_sh_q, tx_sh_d;
    logic        tx_load;
    logic [7:0]  tx_byte;
    logic        tx_done;

    assign tx_done = tx_busy_q && (tx_cnt_q == BitLast) && (tx_bit_q == 4'd9);

    // A load in the tx_done cycle starts the next start bit with no idle gap.
    always_comb begin
        tx_busy_d = tx_busy_q;
        txd_d     = txd_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == BitLast) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    txd_d     = 1'b1;
                    tx_bit_d  = '0;
                end else begin
                    txd_d    = tx_sh_q[0];
                    tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 16'd1;
            end
        end
        if (tx_load) begin
            tx_busy_d = 1'b1;
            txd_d     = 1'b0;
            tx_sh_d   = {1'b1, tx_byte};
            tx_cnt_d  = '0;
            tx_bit_d  = '0;
        end
    end

    // ---------------- command FSM ----------------
    state_e      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] datao_q, datao_d;
    logic [23:0] reply_q, reply_d;
    logic [1:0]  reply_left_q, reply_left_d;
    logic        err_q, err_d;

    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        byte_cnt_d   = byte_cnt_q;
        addr_d       = addr_q;
        datao_d      = datao_q;
        reply_d      = reply_q;
        reply_left_d = reply_left_q;
        err_d        = err_q;
        tx_load      = 1'b0;
        tx_byte      = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    byte_cnt_d = '0;
                    if (rx_sh_q == 8'h57) begin
                        state_d    = StGetA;
                        is_write_d = 1'b1;
                    end else if (rx_sh_q == 8'h52) begin
                        state_d    = StGetA;
                        is_write_d = 1'b0;
                    end else begin
                        tx_load      = 1'b1;
                        tx_byte      = 8'h3F;
                        reply_left_d = '0;
                        state_d      = StReply;
                    end
                end
            end
            StGetA: begin
                if (rx_valid) begin
                    addr_d     = {addr_q[23:0], rx_sh_q};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = is_write_q ? StGetD : StBusR;
                    end
                end
            end
            StGetD: begin
                if (rx_valid) begin
                    datao_d    = {datao_q[23:0], rx_sh_q};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StBusW;
                    end
                end
            end
            StBusW: begin
                tx_load      = 1'b1;
                tx_byte      = 8'h4B;
                reply_left_d = '0;
                state_d      = StReply;
            end
            StBusR: state_d = StRCap;
            StRCap: begin
                tx_load      = 1'b1;
                tx_byte      = DATAI[31:24];
                reply_d      = DATAI[23:0];
                reply_left_d = 2'd3;
                state_d      = StReply;
            end
            StReply: begin
                if (tx_done) begin
                    if (reply_left_q != 2'd0) begin
                        tx_load      = 1'b1;
                        tx_byte      = reply_q[23:16];
                        reply_d      = {reply_q[15:0], 8'h00};
                        reply_left_d = reply_left_q - 2'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (rx_frame_err) begin
            err_d = 1'b1;
        end
        // Bytes arriving while the bus op or reply is in flight are dropped.
        if (rx_valid && (state_q inside {StBusW, StBusR, StRCap, StReply})) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            rxd_s1_q     <= 1'b0;
            rxd_s2_q     <= 1'b0;
            rxd_prev_q   <= 1'b0;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_sh_q      <= '0;
            tx_busy_q    <= 1'b0;
            txd_q        <= 1'b1;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_sh_q      <= '0;
            state_q      <= StIdle;
            is_write_q   <= 1'b0;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            datao_q      <= '0;
            reply_q      <= '0;
            reply_left_q <= '0;
            err_q        <= 1'b0;
        end else begin
            rxd_s1_q     <= RXD;
            rxd_s2_q     <= rxd_s1_q;
            rxd_prev_q   <= rxd_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_sh_q      <= rx_sh_d;
            tx_busy_q    <= tx_busy_d;
            txd_q        <= txd_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_sh_q      <= tx_sh_d;
            state_q      <= state_d;
            is_write_q   <= is_write_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            datao_q      <= datao_d;
            reply_q      <= reply_d;
            reply_left_q <= reply_left_d;
            err_q        <= err_d;
        end
    end

    assign TXD   = txd_q;
    assign RD    = (state_q == StBusR);
    assign WR    = (state_q == StBusW);
    assign BE    = ((state_q == StBusR) || (state_q == StBusW)) ? 4'hF : 4'h0;
    assign ADDR  = addr_q;
    assign DATAO = datao_q;
    assign BUSY  = (state_q != StIdle);
    assign ERR   = err_q;

endmodule

// File: tb/tb_darkuart_bridge.sv
// Directed bench for darkuart_bridge at BAUD_DIV=4: drives serial commands, decodes TXD,
// and observes the bus strobes.
module tb_darkuart_bridge;

    localparam int BD = 4;

    logic        clk, res, rxd;
    logic        txd, rd, wr, busy, err;
    logic [3:0]  be;
    logic [31:0] addr, datao, datai;

    darkuart_bridge #(.BAUD_DIV(BD)) dut (
        .CLK  (clk),
        .RES  (res),
        .RXD  (rxd),
        .TXD  (txd),
        .RD   (rd),
        .WR   (wr),
        .BE   (be),
        .ADDR (addr),
        .DATAO(datao),
        .DATAI(datai),
        .BUSY (busy),
        .ERR  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus slave: read data is valid only in the cycle after the RD pulse.
    logic rd_d1 = 1'b0;
    int   cyc   = 0;
    always @(posedge clk) begin
        rd_d1 <= rd;
        cyc   <= cyc + 1;
    end
    assign datai = rd_d1 ? 32'h12345678 : 32'hA5A5A5A5;

    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, busy_cnt = 0;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [3:0]  wr_be = '0, rd_be = '0;
    always @(negedge clk) begin
        if (wr) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= addr;
            wr_data <= datao;
            wr_be   <= be;
        end
        if (rd) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= addr;
            rd_be   <= be;
        end
        if (rd && wr) both_cnt <= both_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // TXD decoder: samples mid-bit on falling clock edges.
    logic [7:0] tx_q[$];
    logic       tx_stop_q[$];
    int         tx_start_q[$];
    initial begin : tx_mon
        logic [7:0] b;
        logic       prev;
        int         st;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && txd === 1'b0) begin
                st = cyc;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BD) @(negedge clk);
                tx_q.push_back(b);
                tx_stop_q.push_back(txd);
                tx_start_q.push_back(st);
            end
            prev = txd;
        end
    end

    int tx_rd = 0;

    function automatic logic [31:0] tx_at(input int k);
        if (k < tx_q.size()) return {24'h0, tx_q[k]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] stop_at(input int k);
        if (k < tx_stop_q.size()) return {31'h0, tx_stop_q[k]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int start_at(input int k);
        if (k < tx_start_q.size()) return tx_start_q[k];
        return -1000;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BD);
        end
        rxd = stop;
        tick(BD);
        rxd = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && (tx_q.size() - tx_rd) < n; i++) tick(1);
    endtask

    logic [7:0] cmd_w1 [9] = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] cmd_r1 [5] = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h04};
    logic [7:0] cmd_r2 [5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
    logic [7:0] cmd_w2 [9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h20, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    logic [7:0] exp_rd [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    int wr0, rd0, busy0, k;

    initial begin
        res = 1'b1;
        rxd = 1'b1;
        tick(3);
        check_eq("rst_txd",   {31'h0, txd},  32'h1);
        check_eq("rst_rdwr",  {30'h0, rd, wr}, 32'h0);
        check_eq("rst_be",    {28'h0, be},   32'h0);
        check_eq("rst_addr",  addr,          32'h0);
        check_eq("rst_datao", datao,         32'h0);
        check_eq("rst_busy",  {31'h0, busy}, 32'h0);
        check_eq("rst_err",   {31'h0, err},  32'h0);
        res = 1'b0;
        tick(5);

        // Write command
        foreach (cmd_w1[i]) send_byte(cmd_w1[i], 1'b1);
        wait_tx(1, 200);
        check_eq("w_wr_cnt",  wr_cnt,  32'd1);
        check_eq("w_rd_cnt",  rd_cnt,  32'd0);
        check_eq("w_addr",    wr_addr, 32'h00001000);
        check_eq("w_data",    wr_data, 32'hDEADBEEF);
        check_eq("w_be",      {28'h0, wr_be}, 32'hF);
        check_eq("w_reply",   tx_at(tx_rd), 32'h4B);
        check_eq("w_stop",    stop_at(tx_rd), 32'h1);
        tx_rd += 1;
        tick(4);
        check_eq("w_busy_after", {31'h0, busy}, 32'h0);
        check_eq("w_be_after",   {28'h0, be},   32'h0);
        check_eq("w_err",        {31'h0, err},  32'h0);

        // Read command, 4-byte reply back-to-back
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        foreach (cmd_r1[i]) send_byte(cmd_r1[i], 1'b1);
        wait_tx(4, 400);
        check_eq("r_rd_cnt", rd_cnt - rd0, 32'd1);
        check_eq("r_wr_cnt", wr_cnt - wr0, 32'd0);
        check_eq("r_addr",   rd_addr, 32'h00001004);
        check_eq("r_be",     {28'h0, rd_be}, 32'hF);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("r_byte%0d", i), tx_at(tx_rd + i), {24'h0, exp_rd[i]});
            check_eq($sformatf("r_stop%0d", i), stop_at(tx_rd + i), 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("r_gap%0d", i),
                     start_at(tx_rd + i + 1) - start_at(tx_rd + i), 32'd40);
        end
        check_eq("r_total", start_at(tx_rd + 3) + 40 - start_at(tx_rd), 32'd160);
        tx_rd += 4;
        tick(4);
        check_eq("r_busy_after", {31'h0, busy}, 32'h0);

        // Unknown command byte
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        send_byte(8'h41, 1'b1);
        wait_tx(1, 200);
        check_eq("u_reply",  tx_at(tx_rd), 32'h3F);
        check_eq("u_strobe", (wr_cnt - wr0) + (rd_cnt - rd0), 32'd0);
        tx_rd += 1;
        tick(4);
        check_eq("u_busy_after", {31'h0, busy}, 32'h0);

        // Framing error: low stop bit
        send_byte(8'h55, 1'b0);
        tick(10);
        check_eq("fe_err",   {31'h0, err},  32'h1);
        check_eq("fe_busy",  {31'h0, busy}, 32'h0);
        check_eq("fe_no_tx", tx_q.size() - tx_rd, 32'd0);
        rd0 = rd_cnt;
        foreach (cmd_r2[i]) send_byte(cmd_r2[i], 1'b1);
        wait_tx(4, 400);
        check_eq("fe_rd_cnt", rd_cnt - rd0, 32'd1);
        check_eq("fe_rd_addr", rd_addr, 32'h00000008);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("fe_byte%0d", i), tx_at(tx_rd + i), {24'h0, exp_rd[i]});
        end
        tx_rd += 4;
        tick(4);

        // One-clock glitch on RXD
        busy0 = busy_cnt;
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(60);
        check_eq("gl_busy",  busy_cnt - busy0, 32'd0);
        check_eq("gl_err",   {31'h0, err}, 32'h1);
        check_eq("gl_no_tx", tx_q.size() - tx_rd, 32'd0);

        // Reset in the middle of a 'K' reply
        foreach (cmd_w2[i]) send_byte(cmd_w2[i], 1'b1);
        k = 0;
        while (k < 200 && txd !== 1'b0) begin
            tick(1);
            k++;
        end
        check_eq("rs_reply_started", {31'h0, txd}, 32'h0);
        tick(15);
        res = 1'b1;
        tick(1);
        check_eq("rs_txd",  {31'h0, txd},  32'h1);
        check_eq("rs_busy", {31'h0, busy}, 32'h0);
        check_eq("rs_err",  {31'h0, err},  32'h0);
        check_eq("rs_addr", addr, 32'h0);
        res = 1'b0;
        tick(60);
        tx_rd = tx_q.size();
        wr0 = wr_cnt;
        foreach (cmd_w2[i]) send_byte(cmd_w2[i], 1'b1);
        wait_tx(1, 200);
        check_eq("rs_wr_cnt", wr_cnt - wr0, 32'd1);
        check_eq("rs_wr_addr", wr_addr, 32'h00000020);
        check_eq("rs_wr_data", wr_data, 32'hCAFEF00D);
        check_eq("rs_reply",   tx_at(tx_rd), 32'h4B);
        tick(4);
        check_eq("rs_busy_after", {31'h0, busy}, 32'h0);

        check_eq("rd_wr_overlap", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
